// File: rtl/complex_mult_pipe.sv
// Complex multiply a*b (or a*conj(b)) with round-half-up, saturate/wrap, and an overflow beat counter.
// Fixed 3-cycle latency at 1 beat/cycle; all stages stall together while the output is held (s_ready = !m_valid | m_ready).
module complex_mult_pipe #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 12,
  parameter int FRAC_W = 10,
  parameter int OUT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] re_a,
  input  logic signed [DATA_W-1:0] im_a,
  input  logic signed [COEF_W-1:0] re_b,
  input  logic signed [COEF_W-1:0] im_b,
  input  logic                     conj,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  re_out,
  output logic signed [OUT_W-1:0]  im_out,
  output logic                     ovf,
  output logic [15:0]              sat_cnt,
  input  logic                     cnt_clr
);
  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC_W - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                     w_en;
  logic                     r_v1, r_v2, r_v3;
  logic signed [DATA_W-1:0] r_re_a, r_im_a;
  logic signed [COEF_W-1:0] r_re_b, r_im_b;
  logic                     r_conj1, r_conj2;
  logic signed [PW-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [SW-1:0]     w_sum_re, w_sum_im, w_sh_re, w_sh_im;
  logic [OUT_W:0]           w_lim_re, w_lim_im;
  logic                     w_ovf;
  logic [OUT_W-1:0]         r_re_out, r_im_out;
  logic                     r_ovf;
  logic [15:0]              r_sat_cnt;

  // Returns {out_of_range, limited value}; in-range means all bits above the output sign bit match it.
  function automatic logic [OUT_W:0] limit(input logic signed [SW-1:0] v);
    logic [SW-OUT_W:0] hi;
    logic              o;
    hi = v[SW-1:OUT_W-1];
    o  = !((&hi) || !(|hi));
    if (o && SAT_EN) limit = {1'b1, v[SW-1] ? OUT_MIN : OUT_MAX};
    else             limit = {o, v[OUT_W-1:0]};
  endfunction

  assign w_en    = !r_v3 || m_ready;
  assign s_ready = w_en;

  assign w_sum_re = r_conj2 ? SW'(r_p_rr) + SW'(r_p_ii) : SW'(r_p_rr) - SW'(r_p_ii);
  assign w_sum_im = r_conj2 ? SW'(r_p_ir) - SW'(r_p_ri) : SW'(r_p_ri) + SW'(r_p_ir);
  assign w_sh_re  = (w_sum_re + RND) >>> FRAC_W;
  assign w_sh_im  = (w_sum_im + RND) >>> FRAC_W;
  assign w_lim_re = limit(w_sh_re);
  assign w_lim_im = limit(w_sh_im);
  assign w_ovf    = w_lim_re[OUT_W] || w_lim_im[OUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_re_a   <= '0;
      r_im_a   <= '0;
      r_re_b   <= '0;
      r_im_b   <= '0;
      r_conj1  <= 1'b0;
      r_conj2  <= 1'b0;
      r_p_rr   <= '0;
      r_p_ii   <= '0;
      r_p_ri   <= '0;
      r_p_ir   <= '0;
      r_re_out <= '0;
      r_im_out <= '0;
      r_ovf    <= 1'b0;
    end else if (w_en) begin
      r_v1    <= s_valid;
      r_re_a  <= re_a;
      r_im_a  <= im_a;
      r_re_b  <= re_b;
      r_im_b  <= im_b;
      r_conj1 <= conj;
      r_v2    <= r_v1;
      r_p_rr  <= PW'(r_re_a) * PW'(r_re_b);
      r_p_ii  <= PW'(r_im_a) * PW'(r_im_b);
      r_p_ri  <= PW'(r_re_a) * PW'(r_im_b);
      r_p_ir  <= PW'(r_im_a) * PW'(r_re_b);
      r_conj2 <= r_conj1;
      r_v3    <= r_v2;
      // Output registers only change on a real beat, so bubbles leave the last result visible.
      if (r_v2) begin
        r_re_out <= w_lim_re[OUT_W-1:0];
        r_im_out <= w_lim_im[OUT_W-1:0];
        r_ovf    <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (cnt_clr) begin
      r_sat_cnt <= '0;
    end else if (w_en && r_v2 && w_ovf && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign m_valid = r_v3;
  assign re_out  = r_re_out;
  assign im_out  = r_im_out;
  assign ovf     = r_ovf;
  assign sat_cnt = r_sat_cnt;
endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: saturating and wrapping instances share one stimulus stream.
module tb_complex_mult_pipe;
  localparam int DW = 16;
  localparam int CW = 12;
  localparam int FW = 10;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_valid = 1'b0, conj = 1'b0, m_ready = 1'b1, cnt_clr = 1'b0;
  logic signed [DW-1:0] re_a = '0, im_a = '0;
  logic signed [CW-1:0] re_b = '0, im_b = '0;
  logic s_ready_s, s_ready_w, m_valid_s, m_valid_w, ovf_s, ovf_w;
  logic signed [OW-1:0] re_out_s, im_out_s, re_out_w, im_out_w;
  logic [15:0] sat_cnt_s, sat_cnt_w;

  complex_mult_pipe #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(FW), .OUT_W(OW), .SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s),
    .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b), .conj(conj),
    .m_valid(m_valid_s), .m_ready(m_ready), .re_out(re_out_s), .im_out(im_out_s),
    .ovf(ovf_s), .sat_cnt(sat_cnt_s), .cnt_clr(cnt_clr));

  complex_mult_pipe #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(FW), .OUT_W(OW), .SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_w),
    .re_a(re_a), .im_a(im_a), .re_b(re_b), .im_b(im_b), .conj(conj),
    .m_valid(m_valid_w), .m_ready(m_ready), .re_out(re_out_w), .im_out(im_out_w),
    .ovf(ovf_w), .sat_cnt(sat_cnt_w), .cnt_clr(cnt_clr));

  typedef struct {
    longint re_s, im_s, re_w, im_w;
    bit     ovf;
    int     en_at;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  int     en_cnt = 0;
  longint model_cnt = 0;
  bit     clr_prev = 1'b0;
  bit     front_seen = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit out_of_range(input longint v);
    return (v > (longint'(1) << (OW-1)) - 1) || (v < -(longint'(1) << (OW-1)));
  endfunction

  function automatic longint sat_val(input longint v);
    if (v > (longint'(1) << (OW-1)) - 1) return (longint'(1) << (OW-1)) - 1;
    if (v < -(longint'(1) << (OW-1)))    return -(longint'(1) << (OW-1));
    return v;
  endfunction

  function automatic longint wrap_val(input longint v);
    longint w;
    w = v & ((longint'(1) << OW) - 1);
    if (w >= (longint'(1) << (OW-1))) w = w - (longint'(1) << OW);
    return w;
  endfunction

  // Exact complex product, round half up, then limit for both output modes.
  task automatic cmul(input longint ra, input longint ia, input longint rb, input longint ib, input bit cj,
                      output longint re_s, output longint im_s, output longint re_w, output longint im_w,
                      output bit o);
    longint sr, si, shr, shi;
    sr  = cj ? ra*rb + ia*ib : ra*rb - ia*ib;
    si  = cj ? ia*rb - ra*ib : ra*ib + ia*rb;
    shr = (sr + (longint'(1) << (FW-1))) >>> FW;
    shi = (si + (longint'(1) << (FW-1))) >>> FW;
    o    = out_of_range(shr) || out_of_range(shi);
    re_s = sat_val(shr);
    im_s = sat_val(shi);
    re_w = wrap_val(shr);
    im_w = wrap_val(shi);
  endtask

  // Scoreboard: every negedge, account the edge just passed, compare, then record this cycle's handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      model_cnt  = 0;
      clr_prev   = 1'b0;
      front_seen = 1'b0;
    end else begin
      if (clr_prev) model_cnt = 0;
      else if (m_valid_s && !front_seen && q.size() > 0 && q[0].ovf && model_cnt != 65535) model_cnt++;
      check("s_ready_rule", s_ready_s, !m_valid_s || m_ready);
      check("sat_cnt_s", sat_cnt_s, model_cnt);
      check("sat_cnt_w", sat_cnt_w, model_cnt);
      check("m_valid_w", m_valid_w, m_valid_s);
      if (m_valid_s) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          if (!front_seen) check("latency_en_edges", en_cnt - q[0].en_at, 3);
          check("re_s", re_out_s, q[0].re_s);
          check("im_s", im_out_s, q[0].im_s);
          check("re_w", re_out_w, q[0].re_w);
          check("im_w", im_out_w, q[0].im_w);
          check("ovf_s", ovf_s, q[0].ovf);
          check("ovf_w", ovf_w, q[0].ovf);
          front_seen = 1'b1;
          if (m_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (s_valid && s_ready_s) begin
        cmul(re_a, im_a, re_b, im_b, conj, e.re_s, e.im_s, e.re_w, e.im_w, e.ovf);
        e.en_at = en_cnt;
        q.push_back(e);
      end
      if (!m_valid_s || m_ready) en_cnt++;
      clr_prev = cnt_clr;
    end
  end

  task automatic directed(input string name, input int ra, input int ia, input int rb, input int ib, input bit cj,
                          input longint er_s, input longint ei_s, input longint er_w, input longint ei_w,
                          input bit eo, input bit chk_cnt, input longint ecnt);
    longint mr_s, mi_s, mr_w, mi_w;
    bit     mo;
    int     lat;
    cmul(ra, ia, rb, ib, cj, mr_s, mi_s, mr_w, mi_w, mo);
    check({name, "_model_re_s"}, mr_s, er_s);
    check({name, "_model_im_s"}, mi_s, ei_s);
    check({name, "_model_re_w"}, mr_w, er_w);
    check({name, "_model_ovf"}, mo, eo);
    re_a = DW'(ra); im_a = DW'(ia); re_b = CW'(rb); im_b = CW'(ib); conj = cj;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m_valid_s) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_latency"}, lat, 3);
    if (lat > 0) begin
      check({name, "_dut_re_s"}, re_out_s, er_s);
      check({name, "_dut_im_s"}, im_out_s, ei_s);
      check({name, "_dut_re_w"}, re_out_w, er_w);
      check({name, "_dut_im_w"}, im_out_w, ei_w);
      check({name, "_dut_ovf"}, ovf_s, eo);
      if (chk_cnt) begin
        check({name, "_sat_cnt_s"}, sat_cnt_s, ecnt);
        check({name, "_sat_cnt_w"}, sat_cnt_w, ecnt);
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic int rnd_op(input int w);
    if ($urandom_range(3) == 0)
      return ($urandom_range(1) == 1) ? (1 << (w-1)) - 1 : -(1 << (w-1));
    return int'($urandom_range((1 << w) - 1)) - (1 << (w-1));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     nb;
    bit     acc;
    longint snap_re, snap_im, snap_ovf;
    int     bp_ra[5], bp_ia[5], bp_rb[5], bp_ib[5];

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_m_valid", m_valid_s, 0);
    check("rst_re_out", re_out_s, 0);
    check("rst_im_out", im_out_s, 0);
    check("rst_ovf", ovf_s, 0);
    check("rst_sat_cnt", sat_cnt_s, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready_s, 1);
    @(posedge clk); #1;

    directed("unity",     1000, 0,    1024, 0,     1'b0, 1000,  0, 1000,  0, 1'b0, 1'b1, 0);
    directed("round_pos", 1,    0,    512,  0,     1'b0, 1,     0, 1,     0, 1'b0, 1'b0, 0);
    directed("round_neg", -1,   0,    512,  0,     1'b0, 0,     0, 0,     0, 1'b0, 1'b0, 0);
    directed("jj",        0,    1024, 0,    1024,  1'b0, -1024, 0, -1024, 0, 1'b0, 1'b0, 0);
    directed("jj_conj",   0,    1024, 0,    1024,  1'b1, 1024,  0, 1024,  0, 1'b0, 1'b0, 0);
    directed("sat",       32767, 32767, 2047, -2047, 1'b0, 32767, 0, -68, 0, 1'b1, 1'b1, 1);

    // Clear coinciding with an overflowing beat's output load: clear wins.
    s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_prio_m_valid", m_valid_s, 1);
    check("clr_prio_ovf", ovf_s, 1);
    check("clr_prio_sat_cnt", sat_cnt_s, 0);
    @(posedge clk); #1;

    // Backpressure: 5 beats, downstream stalls cycles 3..6.
    for (int i = 0; i < 5; i++) begin
      bp_ra[i] = rnd_op(DW); bp_ia[i] = rnd_op(DW); bp_rb[i] = rnd_op(CW); bp_ib[i] = rnd_op(CW);
    end
    nb = 0; snap_re = 0; snap_im = 0; snap_ovf = 0;
    conj = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      m_ready = !(cyc >= 3 && cyc < 7);
      s_valid = (nb < 5);
      if (nb < 5) begin
        re_a = DW'(bp_ra[nb]); im_a = DW'(bp_ia[nb]); re_b = CW'(bp_rb[nb]); im_b = CW'(bp_ib[nb]);
      end
      @(negedge clk);
      if (cyc == 3) begin
        check("bp_first_valid", m_valid_s, 1);
        snap_re = re_out_s; snap_im = im_out_s; snap_ovf = ovf_s;
      end
      if (cyc >= 3 && cyc < 7) check("bp_s_ready_low", s_ready_s, 0);
      if (cyc > 3 && cyc <= 7) begin
        check("bp_stable_re", re_out_s, snap_re);
        check("bp_stable_im", im_out_s, snap_im);
        check("bp_stable_ovf", ovf_s, snap_ovf);
      end
      if (cyc >= 7 && cyc < 12) check("bp_consecutive", m_valid_s, 1);
      acc = s_valid && s_ready_s;
      @(posedge clk); #1;
      if (acc) nb++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    check("bp_all_accepted", nb, 5);

    // Randomized traffic with random stalls and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(9) < 7);
      m_ready = ($urandom_range(3) != 0);
      cnt_clr = ($urandom_range(49) == 0);
      conj    = 1'($urandom_range(1));
      re_a = DW'(rnd_op(DW)); im_a = DW'(rnd_op(DW));
      re_b = CW'(rnd_op(CW)); im_b = CW'(rnd_op(CW));
      @(posedge clk); #1;
    end
    s_valid = 1'b0; cnt_clr = 1'b0; m_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("random_drained", q.size(), 0);

    // Reset mid-stream with three overflowing beats in flight.
    re_a = 16'sd32767; im_a = 16'sd32767; re_b = 12'sd2047; im_b = -12'sd2047; conj = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_m_valid_s", m_valid_s, 0);
    check("midrst_m_valid_w", m_valid_w, 0);
    check("midrst_re_out", re_out_s, 0);
    check("midrst_im_out", im_out_w, 0);
    check("midrst_ovf", ovf_s, 0);
    check("midrst_sat_cnt", sat_cnt_s, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_s_ready", s_ready_s, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_stale", m_valid_s, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
